// File: rtl/prach_ditfft3_pkg.sv
// Shared types and helpers for the PRACH radix-3 DIT first-stage butterfly.
package prach_ditfft3_pkg;

    // Upper bound on interleaved channels; sizes the per-channel x1 store.
    localparam int MAX_NCH = 16;

    // Position of a sample inside its radix-3 triplet.
    typedef enum logic [1:0] {
        SLOT_X0 = 2'd0,
        SLOT_X1 = 2'd1,
        SLOT_X2 = 2'd2
    } slot_e;

    // Clamp a signed value to the two's complement range of 'width' bits.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                  input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/prach_ditfft3_bf1_mc_dly.sv
// Fixed-length control delay line with asynchronous clear.
module prach_ditfft3_bf1_mc_dly #(
    parameter int WIDTH = 2,
    parameter int DELAY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr_d [DELAY];
    logic [WIDTH-1:0] sr_q [DELAY];

    // Shift one position per clock, new value enters at the head.
    always_comb begin
        sr_d[0] = din;
        for (int i = 1; i < DELAY; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    // Delay-line storage; cleared so in-flight control bits vanish on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '{default: '0};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DELAY-1];

endmodule

// File: rtl/prach_ditfft3_bf1_mc.sv
// First-stage radix-3 DIT butterfly, NCH interleaved channels:
// (x0, x1, x2) -> (x0, x1+x2, x2-x1), fixed latency NCH+2, optional bypass.
module prach_ditfft3_bf1_mc
    import prach_ditfft3_pkg::*;
#(
    parameter int DW   = 18,
    parameter int NCH  = 1,
    parameter int GROW = 1,
    localparam int OW  = DW + GROW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] din_dr,
    input  logic signed [DW-1:0] din_di,
    input  logic                 din_dv,
    input  logic                 sync_in,
    input  logic                 bypass,
    output logic signed [OW-1:0] dout_dr,
    output logic signed [OW-1:0] dout_di,
    output logic                 dout_dv,
    output logic                 sync_out,
    output logic                 sat_flag
);

    localparam int L  = NCH + 2;
    // Data stages ahead of the output register; the last one is where x1+x2 lands.
    localparam int NP = L - 1;
    localparam logic [3:0] CH_LAST = 4'(NCH - 1);

    // Widen/clamp a DW+1 result to OW bits; MSB of the return is the clip flag.
    function automatic logic [OW:0] fit(input logic signed [DW:0] v);
        logic signed [63:0] w;
        logic signed [63:0] s;
        w = 64'(v);
        s = (GROW != 0) ? w : sat_to(w, OW);
        return {(s != w), s[OW-1:0]};
    endfunction

    slot_e       slot_q, slot_d, cur_slot;
    logic [3:0]  ch_q, ch_d, cur_ch;
    logic        bypass_q, bypass_d, byp_eff, grp_start;

    logic signed [DW-1:0] x1r_q [MAX_NCH];
    logic signed [DW-1:0] x1r_d [MAX_NCH];
    logic signed [DW-1:0] x1i_q [MAX_NCH];
    logic signed [DW-1:0] x1i_d [MAX_NCH];

    logic signed [OW-1:0] pr_q [NP];
    logic signed [OW-1:0] pr_d [NP];
    logic signed [OW-1:0] pi_q [NP];
    logic signed [OW-1:0] pi_d [NP];
    logic                 ps_q [NP];
    logic                 ps_d [NP];
    logic                 pt_q [NP];
    logic                 pt_d [NP];

    logic [OW:0] sum_r, sum_i, dif_r, dif_i;

    logic signed [OW-1:0] dout_dr_q, dout_dr_d, dout_di_q, dout_di_d;
    logic                 sat_flag_q, sat_flag_d;
    logic [1:0]           dly_out;

    // Slot/channel tracking, sync realignment and group-boundary bypass latch.
    always_comb begin
        cur_slot = slot_q;
        cur_ch   = ch_q;
        if (din_dv && sync_in) begin
            cur_slot = SLOT_X0;
            cur_ch   = '0;
        end
        grp_start = din_dv && (cur_slot == SLOT_X0) && (cur_ch == '0);
        byp_eff   = grp_start ? bypass : bypass_q;
        bypass_d  = byp_eff;
        slot_d    = slot_q;
        ch_d      = ch_q;
        if (din_dv) begin
            if (cur_ch == CH_LAST) begin
                ch_d = '0;
                case (cur_slot)
                    SLOT_X0: slot_d = SLOT_X1;
                    SLOT_X1: slot_d = SLOT_X2;
                    default: slot_d = SLOT_X0;
                endcase
            end else begin
                ch_d   = cur_ch + 4'd1;
                slot_d = cur_slot;
            end
        end
    end

    // Datapath: store x1 per channel; on x2 drop x2-x1 at the head of the line
    // and x1+x2 into the slot just before the output, overwriting the delayed x1 entry.
    always_comb begin
        x1r_d = x1r_q;
        x1i_d = x1i_q;
        if (din_dv && (cur_slot == SLOT_X1)) begin
            x1r_d[cur_ch] = din_dr;
            x1i_d[cur_ch] = din_di;
        end
        sum_r = fit({x1r_q[cur_ch][DW-1], x1r_q[cur_ch]} + {din_dr[DW-1], din_dr});
        sum_i = fit({x1i_q[cur_ch][DW-1], x1i_q[cur_ch]} + {din_di[DW-1], din_di});
        dif_r = fit({din_dr[DW-1], din_dr} - {x1r_q[cur_ch][DW-1], x1r_q[cur_ch]});
        dif_i = fit({din_di[DW-1], din_di} - {x1i_q[cur_ch][DW-1], x1i_q[cur_ch]});

        pr_d[0] = OW'(din_dr);
        pi_d[0] = OW'(din_di);
        ps_d[0] = 1'b0;
        pt_d[0] = din_dv;
        for (int i = 1; i < NP; i++) begin
            pr_d[i] = pr_q[i-1];
            pi_d[i] = pi_q[i-1];
            ps_d[i] = ps_q[i-1];
            pt_d[i] = pt_q[i-1];
        end
        if (din_dv && (cur_slot == SLOT_X2) && !byp_eff) begin
            pr_d[0]    = dif_r[OW-1:0];
            pi_d[0]    = dif_i[OW-1:0];
            ps_d[0]    = dif_r[OW] | dif_i[OW];
            pr_d[NP-1] = sum_r[OW-1:0];
            pi_d[NP-1] = sum_i[OW-1:0];
            ps_d[NP-1] = sum_r[OW] | sum_i[OW];
        end

        dout_dr_d  = dout_dr_q;
        dout_di_d  = dout_di_q;
        sat_flag_d = 1'b0;
        if (pt_q[NP-1]) begin
            dout_dr_d  = pr_q[NP-1];
            dout_di_d  = pi_q[NP-1];
            sat_flag_d = ps_q[NP-1];
        end
    end

    // Control state and outputs; cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= SLOT_X0;
            ch_q       <= '0;
            bypass_q   <= 1'b0;
            pt_q       <= '{default: 1'b0};
            dout_dr_q  <= '0;
            dout_di_q  <= '0;
            sat_flag_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            ch_q       <= ch_d;
            bypass_q   <= bypass_d;
            pt_q       <= pt_d;
            dout_dr_q  <= dout_dr_d;
            dout_di_q  <= dout_di_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    // Data storage without reset; contents are qualified by the valid tags.
    always_ff @(posedge clk) begin
        x1r_q <= x1r_d;
        x1i_q <= x1i_d;
        pr_q  <= pr_d;
        pi_q  <= pi_d;
        ps_q  <= ps_d;
    end

    prach_ditfft3_bf1_mc_dly #(
        .WIDTH (2),
        .DELAY (L)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .din  ({sync_in, din_dv}),
        .dout (dly_out)
    );

    assign {sync_out, dout_dv} = dly_out;
    assign dout_dr  = dout_dr_q;
    assign dout_di  = dout_di_q;
    assign sat_flag = sat_flag_q;

endmodule

// File: tb/tb_prach_ditfft3_bf1_mc.sv
// Bench: two instances (NCH=2/GROW=1 and NCH=1/GROW=0) share one stimulus
// stream; expected outputs come from a triplet-level reference model.
module tb_prach_ditfft3_bf1_mc;

    localparam int NCYC = 660;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [17:0] din_dr = '0, din_di = '0;
    logic din_dv = 1'b0, sync_in = 1'b0, bypass = 1'b0;

    logic signed [18:0] d0_r, d0_i;
    logic dv0, sy0, sat0;
    logic signed [17:0] d1_r, d1_i;
    logic dv1, sy1, sat1;

    prach_ditfft3_bf1_mc #(.DW(18), .NCH(2), .GROW(1)) u0 (
        .clk(clk), .rst(rst), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
        .sync_in(sync_in), .bypass(bypass), .dout_dr(d0_r), .dout_di(d0_i),
        .dout_dv(dv0), .sync_out(sy0), .sat_flag(sat0));

    prach_ditfft3_bf1_mc #(.DW(18), .NCH(1), .GROW(0)) u1 (
        .clk(clk), .rst(rst), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
        .sync_in(sync_in), .bypass(bypass), .dout_dr(d1_r), .dout_di(d1_i),
        .dout_dv(dv1), .sync_out(sy1), .sat_flag(sat1));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // stimulus plan
    bit s_dv [NCYC], s_sy [NCYC], s_byp [NCYC], s_rst [NCYC];
    int s_r [NCYC], s_i [NCYC];
    int wc = 0;
    bit byp_cur = 1'b0;

    // recorded DUT outputs and model expectations, per instance
    bit rst_rec [NCYC];
    int a_r [2][NCYC], a_i [2][NCYC];
    bit a_dv [2][NCYC], a_sy [2][NCYC], a_sat [2][NCYC];
    int e_r [2][NCYC], e_i [2][NCYC];
    bit e_dv [2][NCYC], e_sy [2][NCYC], e_sat [2][NCYC], e_care [2][NCYC];

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic add(input bit dv, input bit sy, input int r, input int i);
        s_dv[wc] = dv; s_sy[wc] = sy; s_byp[wc] = byp_cur; s_rst[wc] = 1'b0;
        s_r[wc] = r; s_i[wc] = i;
        wc++;
    endtask

    task automatic add_rst();
        add(1'b0, 1'b0, 0, 0);
        s_rst[wc-1] = 1'b1;
    endtask

    function automatic int rnd_val();
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 0) return 131071;
        if (k == 1) return -131072;
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    function automatic int clampv(input int v, input bit grow);
        if (grow) return v;
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    task automatic emit(input int k, input int lat, input int t, input int r, input int i, input bit sat);
        int o;
        o = t + lat;
        if (o < NCYC && e_dv[k][o]) begin
            e_care[k][o] = 1'b1;
            e_r[k][o] = r;
            e_i[k][o] = i;
            e_sat[k][o] = sat;
        end
    endtask

    // Reference: outputs are inputs delayed by lat unless a reset intervenes;
    // data is formed per completed group of 3*n samples (sync restarts a group).
    task automatic build(input int k, input int n, input bit grow);
        int lat;
        int g[$];
        bit wiped;
        lat = n + 2;
        for (int c = 0; c < NCYC; c++) begin
            e_dv[k][c] = 0; e_sy[k][c] = 0; e_sat[k][c] = 0; e_care[k][c] = 0;
            e_r[k][c] = 0; e_i[k][c] = 0;
        end
        for (int t = 0; t < NCYC; t++) begin
            if (s_dv[t] && !s_rst[t]) begin
                wiped = 1'b0;
                for (int r = t + 1; r < t + lat && r < NCYC; r++)
                    if (s_rst[r]) wiped = 1'b1;
                if (!wiped && t + lat < NCYC) begin
                    e_dv[k][t+lat] = 1'b1;
                    e_sy[k][t+lat] = s_sy[t];
                end
            end
        end
        for (int t = 0; t < NCYC; t++) begin
            if (s_rst[t]) begin
                g.delete();
                continue;
            end
            if (!s_dv[t]) continue;
            if (s_sy[t]) g.delete();
            g.push_back(t);
            if (g.size() == 3 * n) begin
                for (int c = 0; c < n; c++) begin
                    int a, b, d, sr, si, cr, ci;
                    a = g[c]; b = g[n+c]; d = g[2*n+c];
                    emit(k, lat, a, s_r[a], s_i[a], 1'b0);
                    if (s_byp[g[0]]) begin
                        emit(k, lat, b, s_r[b], s_i[b], 1'b0);
                        emit(k, lat, d, s_r[d], s_i[d], 1'b0);
                    end else begin
                        sr = s_r[b] + s_r[d]; si = s_i[b] + s_i[d];
                        cr = clampv(sr, grow); ci = clampv(si, grow);
                        emit(k, lat, b, cr, ci, (cr != sr) || (ci != si));
                        sr = s_r[d] - s_r[b]; si = s_i[d] - s_i[b];
                        cr = clampv(sr, grow); ci = clampv(si, grow);
                        emit(k, lat, d, cr, ci, (cr != sr) || (ci != si));
                    end
                end
                g.delete();
            end
        end
    endtask

    initial begin
        int cnt;
        int ta, tb, tc;
        bit sy;
        // ---- stimulus plan ----
        repeat (3) add_rst();
        ta = wc;
        add(1, 1, 5, 0); add(1, 0, 3, 1); add(1, 0, 10, -2);
        add(1, 0, 0, 0); add(1, 0, 0, 0); add(1, 0, 0, 0);
        add(0, 0, 0, 0); add(0, 0, 0, 0);
        tb = wc;
        add(1, 1, 1, 0); add(1, 0, 2, 0); add(1, 0, 10, 0);
        add(1, 0, 20, 0); add(1, 0, 100, 0); add(1, 0, 200, 0);
        add(0, 0, 0, 0); add(0, 0, 0, 0);
        tc = wc;
        add(1, 1, 0, 0); add(1, 0, 131071, 0); add(1, 0, 1, 0);
        add(1, 0, 0, 0); add(1, 0, -131072, 0); add(1, 0, 0, 0);
        add(0, 0, 0, 0);
        cnt = 0;
        while (wc < 640) begin
            if (wc == 400) begin
                repeat (4) add_rst();
                cnt = 0;
                continue;
            end
            if ($urandom_range(0, 9) == 0) byp_cur = !byp_cur;
            if ((cnt % 6 == 0) && ($urandom_range(0, 3) == 0)) begin
                add(0, 0, rnd_val(), rnd_val());
            end else begin
                sy = ($urandom_range(0, 29) == 0);
                cnt = sy ? 1 : cnt + 1;
                add(1, sy, rnd_val(), rnd_val());
            end
        end
        while (wc < NCYC) add(0, 0, 0, 0);

        // ---- run ----
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            rst_rec[c] = rst;
            a_r[0][c] = int'(d0_r); a_i[0][c] = int'(d0_i);
            a_dv[0][c] = dv0; a_sy[0][c] = sy0; a_sat[0][c] = sat0;
            a_r[1][c] = int'(d1_r); a_i[1][c] = int'(d1_i);
            a_dv[1][c] = dv1; a_sy[1][c] = sy1; a_sat[1][c] = sat1;
            din_dv  = s_dv[c];
            sync_in = s_sy[c];
            bypass  = s_byp[c];
            din_dr  = 18'(s_r[c]);
            din_di  = 18'(s_i[c]);
            if (s_rst[c] && !rst) begin
                #2 rst = 1'b1;
                #1;
                chk("async_rst u0 dr", d0_r, 0);
                chk("async_rst u0 di", d0_i, 0);
                chk("async_rst u0 dv", dv0, 0);
                chk("async_rst u0 sync", sy0, 0);
                chk("async_rst u0 sat", sat0, 0);
                chk("async_rst u1 dr", d1_r, 0);
                chk("async_rst u1 di", d1_i, 0);
                chk("async_rst u1 dv", dv1, 0);
                chk("async_rst u1 sync", sy1, 0);
                chk("async_rst u1 sat", sat1, 0);
            end else if (!s_rst[c] && rst) begin
                #1 rst = 1'b0;
            end
        end

        // ---- directed expectations written out by hand ----
        chk("t1 dr x0", a_r[1][ta+3], 5);
        chk("t1 di x0", a_i[1][ta+3], 0);
        chk("t1 sync_out", a_sy[1][ta+3], 1);
        chk("t1 dr sum", a_r[1][ta+4], 13);
        chk("t1 di sum", a_i[1][ta+4], -1);
        chk("t1 dr dif", a_r[1][ta+5], 7);
        chk("t1 di dif", a_i[1][ta+5], -3);
        chk("t1 dv first", a_dv[1][ta+3], 1);
        chk("t1 dv before", a_dv[1][ta+2], 0);
        chk("t2 out0", a_r[0][tb+4], 1);
        chk("t2 out1", a_r[0][tb+5], 2);
        chk("t2 out2", a_r[0][tb+6], 110);
        chk("t2 out3", a_r[0][tb+7], 220);
        chk("t2 out4", a_r[0][tb+8], 90);
        chk("t2 out5", a_r[0][tb+9], 180);
        chk("t3 sum sat val", a_r[1][tc+4], 131071);
        chk("t3 sum sat flag", a_sat[1][tc+4], 1);
        chk("t3 dif val", a_r[1][tc+5], -131070);
        chk("t3 x0 sat flag", a_sat[1][tc+6], 0);
        chk("t3 dif sat val", a_r[1][tc+8], 131071);
        chk("t3 dif sat flag", a_sat[1][tc+8], 1);

        // ---- model comparison, every cycle ----
        build(0, 2, 1'b1);
        build(1, 1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NCYC; c++) begin
                if (rst_rec[c]) begin
                    chk($sformatf("u%0d c%0d rst dr", k, c), a_r[k][c], 0);
                    chk($sformatf("u%0d c%0d rst di", k, c), a_i[k][c], 0);
                    chk($sformatf("u%0d c%0d rst dv", k, c), a_dv[k][c], 0);
                    chk($sformatf("u%0d c%0d rst sync", k, c), a_sy[k][c], 0);
                    chk($sformatf("u%0d c%0d rst sat", k, c), a_sat[k][c], 0);
                end else begin
                    chk($sformatf("u%0d c%0d dv", k, c), a_dv[k][c], e_dv[k][c]);
                    chk($sformatf("u%0d c%0d sync", k, c), a_sy[k][c], e_sy[k][c]);
                    if (e_dv[k][c] && e_care[k][c]) begin
                        chk($sformatf("u%0d c%0d dr", k, c), a_r[k][c], e_r[k][c]);
                        chk($sformatf("u%0d c%0d di", k, c), a_i[k][c], e_i[k][c]);
                        chk($sformatf("u%0d c%0d sat", k, c), a_sat[k][c], e_sat[k][c]);
                    end else if (!e_dv[k][c]) begin
                        chk($sformatf("u%0d c%0d idle sat", k, c), a_sat[k][c], 0);
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
